// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding, opcodes and the IR capture pattern.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    ST_RTI  = 4'd0,
    ST_TLR  = 4'd1,
    ST_SDRS = 4'd2,
    ST_CDR  = 4'd3,
    ST_SDR  = 4'd4,
    ST_E1DR = 4'd5,
    ST_PDR  = 4'd6,
    ST_E2DR = 4'd7,
    ST_UDR  = 4'd8,
    ST_SIRS = 4'd9,
    ST_CIR  = 4'd10,
    ST_SIR  = 4'd11,
    ST_E1IR = 4'd12,
    ST_PIR  = 4'd13,
    ST_E2IR = 4'd14,
    ST_UIR  = 4'd15
  } tap_state_e;

  localparam int unsigned IDCODE_OP = 1;
  localparam int unsigned USER_OP   = 2;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  // BYPASS is all-ones for whatever IR width is in use
  function automatic logic [31:0] bypass_op(input int unsigned ir_w);
    return (32'd1 << ir_w) - 32'd1;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP controller: state register and next-state logic only.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e r_state;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_state <= ST_TLR;
    end else begin
      case (r_state)
        ST_TLR:  r_state <= tms ? ST_TLR  : ST_RTI;
        ST_RTI:  r_state <= tms ? ST_SDRS : ST_RTI;
        ST_SDRS: r_state <= tms ? ST_SIRS : ST_CDR;
        ST_CDR:  r_state <= tms ? ST_E1DR : ST_SDR;
        ST_SDR:  r_state <= tms ? ST_E1DR : ST_SDR;
        ST_E1DR: r_state <= tms ? ST_UDR  : ST_PDR;
        ST_PDR:  r_state <= tms ? ST_E2DR : ST_PDR;
        ST_E2DR: r_state <= tms ? ST_UDR  : ST_SDR;
        ST_UDR:  r_state <= tms ? ST_SDRS : ST_RTI;
        ST_SIRS: r_state <= tms ? ST_TLR  : ST_CIR;
        ST_CIR:  r_state <= tms ? ST_E1IR : ST_SIR;
        ST_SIR:  r_state <= tms ? ST_E1IR : ST_SIR;
        ST_E1IR: r_state <= tms ? ST_UIR  : ST_PIR;
        ST_PIR:  r_state <= tms ? ST_E2IR : ST_PIR;
        ST_E2IR: r_state <= tms ? ST_UIR  : ST_SIR;
        ST_UIR:  r_state <= tms ? ST_SDRS : ST_RTI;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: rtl/jtag_tap.sv
// jtag_tap: 1149.1 TAP with IR, BYPASS, IDCODE and optional USER DR; tdo/tdo_en change on negedge tck.
// Define JTAG_TAP_USER_DR_EN to make the USER register functional; otherwise USER decodes as BYPASS.
module jtag_tap
  import jtag_tap_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          USER_DR_W  = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 tdo,
  output logic                 tdo_en,
  output logic [3:0]           tap_state,
  output logic [IR_W-1:0]      ir_q,
  input  logic [USER_DR_W-1:0] user_dr_in,
  output logic [USER_DR_W-1:0] user_dr_out,
  output logic                 user_update
);

  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(IDCODE_OP);
  localparam logic [IR_W-1:0] IR_CAP    = IR_W'(IR_CAPTURE);

  tap_state_e      w_state;
  logic [IR_W-1:0] r_ir_sh;
  logic [IR_W-1:0] r_ir_q;
  logic            r_bypass;
  logic [31:0]     r_id_sh;
  logic            r_tdo;
  logic            r_tdo_en;
  logic            w_sel_id;
  logic            w_sel_user;
  logic            w_user_lsb;
  logic            w_tdo_nxt;
  logic            w_tdo_en_nxt;

  jtag_tap_fsm u_fsm (
    .tck   (tck),
    .trst  (trst),
    .tms   (tms),
    .state (w_state)
  );

  assign w_sel_id = (r_ir_q == OP_IDCODE);

  // TLR is only reachable from SIRS or TLR with tms=1, so IDCODE is in place on arrival
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_ir_sh <= '0;
      r_ir_q  <= OP_IDCODE;
    end else begin
      case (w_state)
        ST_CIR:  r_ir_sh <= IR_CAP;
        ST_SIR:  r_ir_sh <= {tdi, r_ir_sh[IR_W-1:1]};
        ST_UIR:  r_ir_q  <= r_ir_sh;
        default: ;
      endcase
      if ((w_state == ST_TLR || w_state == ST_SIRS) && tms) begin
        r_ir_q <= OP_IDCODE;
      end
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_bypass <= 1'b0;
      r_id_sh  <= '0;
    end else if (w_state == ST_CDR) begin
      r_bypass <= 1'b0;
      if (w_sel_id) r_id_sh <= IDCODE_VAL;
    end else if (w_state == ST_SDR) begin
      r_bypass <= tdi;
      if (w_sel_id) r_id_sh <= {tdi, r_id_sh[31:1]};
    end
  end

`ifdef JTAG_TAP_USER_DR_EN
  localparam logic [IR_W-1:0] OP_USER = IR_W'(USER_OP);

  logic [USER_DR_W-1:0] r_user_sh;
  logic [USER_DR_W-1:0] r_user_dr_out;
  logic                 r_user_update;
  logic                 w_enter_udr;

  assign w_sel_user  = (r_ir_q == OP_USER);
  assign w_enter_udr = (w_state == ST_E1DR || w_state == ST_E2DR) && tms;

  // Load on the edge into UDR so user_dr_out and user_update are both visible during UDR
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_user_sh     <= '0;
      r_user_dr_out <= '0;
      r_user_update <= 1'b0;
    end else begin
      r_user_update <= w_enter_udr && w_sel_user;
      if (w_enter_udr && w_sel_user) r_user_dr_out <= r_user_sh;
      if (w_sel_user && w_state == ST_CDR) begin
        r_user_sh <= user_dr_in;
      end else if (w_sel_user && w_state == ST_SDR) begin
        r_user_sh <= (r_user_sh >> 1) | (USER_DR_W'(tdi) << (USER_DR_W - 1));
      end
    end
  end

  assign w_user_lsb  = r_user_sh[0];
  assign user_dr_out = r_user_dr_out;
  assign user_update = r_user_update;
`else
  logic w_unused_user_in;

  assign w_unused_user_in = ^user_dr_in;
  assign w_sel_user       = 1'b0;
  assign w_user_lsb       = 1'b0;
  assign user_dr_out      = '0;
  assign user_update      = 1'b0;
`endif

  always_comb begin
    w_tdo_nxt    = 1'b0;
    w_tdo_en_nxt = 1'b0;
    case (w_state)
      ST_SDR: begin
        w_tdo_en_nxt = 1'b1;
        if (w_sel_id)        w_tdo_nxt = r_id_sh[0];
        else if (w_sel_user) w_tdo_nxt = w_user_lsb;
        else                 w_tdo_nxt = r_bypass;
      end
      ST_SIR: begin
        w_tdo_en_nxt = 1'b1;
        w_tdo_nxt    = r_ir_sh[0];
      end
      default: ;
    endcase
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo_nxt;
      r_tdo_en <= w_tdo_en_nxt;
    end
  end

  assign tdo       = r_tdo;
  assign tdo_en    = r_tdo_en;
  assign tap_state = w_state;
  assign ir_q      = r_ir_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: state-walk table, hand sequences and random tms/tdi against a reference model.
module tb_jtag_tap;

  localparam int IR_W = 4;
`ifdef JTAG_TAP_USER_DR_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif

  logic       tck = 1'b0;
  logic       trst, tms, tdi;
  logic       tdo, tdo_en, user_update;
  logic [3:0] tap_state, ir_q;
  logic [7:0] user_dr_in, user_dr_out;

  jtag_tap #(.IR_W(4), .USER_DR_W(8), .IDCODE_VAL(32'h1234_5001)) dut (
    .tck         (tck),
    .trst        (trst),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .tap_state   (tap_state),
    .ir_q        (ir_q),
    .user_dr_in  (user_dr_in),
    .user_dr_out (user_dr_out),
    .user_update (user_update)
  );

  always #5 tck = ~tck;

  int n_checks = 0;
  int n_fail   = 0;

  // Transition table straight from the standard state diagram
  int nxt0 [16] = '{0, 0, 3, 4, 4, 6, 6, 4, 0, 10, 11, 11, 13, 13, 11, 0};
  int nxt1 [16] = '{2, 1, 9, 5, 5, 8, 7, 8, 2, 1, 12, 12, 15, 14, 15, 2};

  int          m_st, m_ir_sh, m_ir_q, m_w, m_uout;
  logic [63:0] m_dr;
  bit          m_upd, m_tdo, m_en;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sel();
    if (m_ir_q == 1) return 1;
    if (USER_EN && m_ir_q == 2) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = 1; m_ir_sh = 0; m_ir_q = 1; m_w = 1; m_dr = 0;
    m_uout = 0; m_upd = 0; m_tdo = 0; m_en = 0;
  endtask

  task automatic model_step(input bit t_tms, input bit t_tdi);
    int ns;
    ns = t_tms ? nxt1[m_st] : nxt0[m_st];
    case (m_st)
      10: m_ir_sh = 1;
      11: m_ir_sh = (m_ir_sh >> 1) | (int'(t_tdi) << (IR_W - 1));
      15: m_ir_q = m_ir_sh;
      3: begin
        case (sel())
          1:       begin m_dr = 64'h1234_5001; m_w = 32; end
          2:       begin m_dr = 64'(user_dr_in); m_w = 8; end
          default: begin m_dr = 0; m_w = 1; end
        endcase
      end
      4: m_dr = (m_dr >> 1) | (64'(t_tdi) << (m_w - 1));
      default: ;
    endcase
    m_upd = 0;
    if (ns == 8 && sel() == 2) begin
      m_uout = int'(m_dr[7:0]);
      m_upd  = 1;
    end
    if (ns == 1) m_ir_q = 1;
    m_st  = ns;
    m_en  = (ns == 4 || ns == 11);
    m_tdo = (ns == 4) ? m_dr[0] : (ns == 11) ? m_ir_sh[0] : 1'b0;
  endtask

  task automatic compare_all();
    chk("tap_state",   64'(tap_state),   64'(m_st));
    chk("ir_q",        64'(ir_q),        64'(m_ir_q));
    chk("tdo",         64'(tdo),         64'(m_tdo));
    chk("tdo_en",      64'(tdo_en),      64'(m_en));
    chk("user_dr_out", 64'(user_dr_out), 64'(m_uout));
    chk("user_update", 64'(user_update), 64'(m_upd));
  endtask

  task automatic tick(input bit t_tms, input bit t_tdi);
    tms = t_tms;
    tdi = t_tdi;
    @(posedge tck);
    model_step(t_tms, t_tdi);
    @(negedge tck);
    #1;
    compare_all();
  endtask

  // Called just after a negedge; pulses trst between edges
  task automatic do_reset();
    trst = 1'b0;
    tms  = 1'b1;
    tdi  = 1'b0;
    #1;
    model_reset();
    compare_all();
    trst = 1'b1;
    @(negedge tck);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = tdo;
      tick(i == 3, val[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  typedef struct {
    bit tms;
    int exp_state;
  } vec_t;

  vec_t walk [24];

  initial begin
    logic [31:0] rd;
    logic [3:0]  cap;
    logic [7:0]  rd8, pat8;
    logic [15:0] pat;
    logic        prev;

    trst = 1'b0; tms = 1'b1; tdi = 1'b0; user_dr_in = 8'h00;
    @(negedge tck);
    #1;
    do_reset();

    walk = '{'{0, 0}, '{1, 2}, '{0, 3}, '{0, 4}, '{1, 5}, '{0, 6}, '{0, 6}, '{1, 7},
             '{0, 4}, '{1, 5}, '{1, 8}, '{1, 2}, '{1, 9}, '{0, 10}, '{0, 11}, '{1, 12},
             '{0, 13}, '{1, 14}, '{0, 11}, '{1, 12}, '{1, 15}, '{1, 2}, '{1, 9}, '{1, 1}};
    for (int i = 0; i < 24; i++) begin
      tick(walk[i].tms, 1'b0);
      chk($sformatf("walk[%0d]", i), 64'(tap_state), 64'(walk[i].exp_state));
    end

    // Five tms=1 cycles from a random state reach TLR with IDCODE selected
    do_reset();
    for (int i = 0; i < 17; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tlr5_state", 64'(tap_state), 64'd1);
    chk("tlr5_ir_q",  64'(ir_q),      64'h1);

    // IDCODE readout
    do_reset();
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 32; i++) begin
      rd[i] = tdo;
      tick(i == 31, 0);
    end
    chk("idcode_read", 64'(rd), 64'h1234_5001);
    chk("idcode_e1dr", 64'(tap_state), 64'd5);
    tick(1, 0); tick(0, 0);

    // BYPASS: capture pattern on IR, then a one-tck echo through the DR
    load_ir(4'b1111, cap);
    chk("ir_capture", 64'(cap), 64'h1);
    chk("ir_bypass",  64'(ir_q), 64'hF);
    tick(1, 0); tick(0, 0); tick(0, 0);
    pat  = 16'($urandom);
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bypass_echo[%0d]", i), 64'(tdo), 64'(prev));
      prev = pat[i];
      tick(i == 15, pat[i]);
    end
    tick(1, 0); tick(0, 0);

    // trst mid-shift under USER: partial shift discarded, user_dr_out untouched
    user_dr_in = 8'h5A;
    load_ir(4'b0010, cap);
    tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 1); tick(0, 1);
    #2;
    trst = 1'b0;
    #1;
    chk("trst_state",   64'(tap_state),   64'd1);
    chk("trst_tdo",     64'(tdo),         64'd0);
    chk("trst_tdo_en",  64'(tdo_en),      64'd0);
    chk("trst_user_out", 64'(user_dr_out), 64'h0);
    chk("trst_ir_q",    64'(ir_q),        64'h1);
    model_reset();
    trst = 1'b1;
    @(negedge tck);
    #1;

    // USER capture/shift/update (BYPASS behaviour when the feature is off)
    user_dr_in = 8'hA5;
    tick(0, 0);
    load_ir(4'b0010, cap);
    tick(1, 0); tick(0, 0); tick(0, 0);
    pat8 = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      rd8[i] = tdo;
      tick(i == 7, pat8[i]);
      chk("user_no_early_update", 64'(user_update), 64'd0);
    end
    tick(1, 0);
    if (USER_EN) begin
      chk("user_read",   64'(rd8),         64'hA5);
      chk("user_out",    64'(user_dr_out), 64'h3C);
      chk("user_update", 64'(user_update), 64'd1);
    end else begin
      chk("user_read_bypass", 64'(rd8),         64'h78);
      chk("user_out_off",     64'(user_dr_out), 64'h0);
      chk("user_update_off",  64'(user_update), 64'd0);
    end
    tick(0, 0);
    chk("user_update_pulse", 64'(user_update), 64'd0);
    chk("user_out_hold",     64'(user_dr_out), USER_EN ? 64'h3C : 64'h0);

    // Random tms/tdi/user_dr_in against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) user_dr_in = 8'($urandom);
      tick($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap.md
# jtag_tap

Parametrised IEEE 1149.1 Test Access Port: full 16-state TAP controller plus instruction register and BYPASS, IDCODE and optional USER data registers. Sits at the chip boundary between the JTAG pins and on-chip debug/config logic. Generalises the bare TAP state machine with configurable IR and user-DR widths, real shift paths, and a negedge-timed TDO driver.

## Interface
- IR_W, 4: instruction register width, at least 2.
- USER_DR_W, 8: USER data register width, at least 1.
- IDCODE_VAL, 32'h1234_5001: IDCODE value; bit 0 must be 1.
- tck  in  1  TAP clock; the only clock.
- trst  in  1  asynchronous active-low reset.
- tms  in  1  mode select, sampled on posedge tck.
- tdi  in  1  serial data in, sampled on posedge tck.
- tdo  out  1  serial data out, changes on negedge tck.
- tdo_en  out  1  high while tdo is valid (Shift-DR/Shift-IR), registered on negedge.
- tap_state  out  4  current TAP state encoding.
- ir_q  out  IR_W  active instruction.
- user_dr_in  in  USER_DR_W  parallel value captured in Capture-DR under USER.
- user_dr_out  out  USER_DR_W  parallel value loaded in Update-DR under USER.
- user_update  out  1  one-tck pulse, high in the cycle user_dr_out is loaded.

## Operation
- State encoding: RTI=0, TLR=1, SDRS=2, CDR=3, SDR=4, E1DR=5, PDR=6, E2DR=7, UDR=8, SIRS=9, CIR=10, SIR=11, E1IR=12, PIR=13, E2IR=14, UIR=15.
- Transitions are standard 1149.1. TLR: tms 1 stays in TLR, 0 goes to RTI. RTI: 1 to SDRS, 0 stays. SDRS: 1 to SIRS, 0 to CDR. SIRS: 1 to TLR, 0 to CIR. CxR and SxR: 1 to E1xR, 0 to SxR. E1xR: 1 to UxR, 0 to PxR. PxR: 1 to E2xR, 0 stays. E2xR: 1 to UxR, 0 to SxR. UxR: 1 to SDRS, 0 to RTI.
- Five consecutive tms=1 cycles reach TLR from any state.
- Opcodes: BYPASS is all-ones; IDCODE = 1; USER = 2. Any other opcode selects BYPASS.
- IR shifter:
  - CIR loads {zeros, 2'b01}.
  - SIR shifts right, with tdi entering the MSB.
  - UIR copies the shifter into ir_q.
  - ir_q = IDCODE in TLR and on reset.
- DR select follows ir_q:
  - BYPASS: 1-bit register, captures 0.
  - IDCODE: captures IDCODE_VAL.
  - USER: captures user_dr_in.
  - All DRs shift right LSB-first in SDR, with tdi entering the MSB.
- UDR under USER: user_dr_out is loaded from the shifter and user_update pulses. Under other instructions neither changes.
- tdo carries the selected shifter LSB, or the IR shifter LSB in SIR.
- tdo and tdo_en are 0 outside shift states.

## Timing
- Reset values: tap_state=TLR, ir_q=IDCODE, tdo=0, tdo_en=0, user_dr_out=0, user_update=0, all shifters 0.
- trst asserts asynchronously at any point, including mid-shift. The partial shift is discarded and user_dr_out is not updated.
- State, capture, shift and update all act on posedge tck.
- tdo/tdo_en are registered on the following negedge.
- Latency: the first tdo bit is valid on the negedge after entering SDR/SIR.
- A DR of width N needs N shift cycles. The last bit is shifted on the SxR to E1xR transition edge (tms=1).
- PxR holds all shifters unchanged for any number of cycles.

## Configuration
- JTAG_TAP_USER_DR_EN defined: USER register and its ports are functional.
- Not defined:
  - USER decodes as BYPASS.
  - user_dr_out is held 0 and user_update is held 0.
  - user_dr_in is ignored.
  - The port list is unchanged.

## Structure
- Package jtag_tap_pkg holds:
  - the 4-bit state encoding constants;
  - the IDCODE, USER and BYPASS opcode constants, the last as a function of IR_W;
  - the IR capture pattern.
- Sub-module jtag_tap_fsm: the state register and next-state logic only (tck, trst, tms in; state out).
- The top instantiates jtag_tap_fsm and adds the registers and the tdo mux.

## Test plan
- Reset, then tms=1 for 5 cycles from a random state: tap_state=1 (TLR) and ir_q=4'b0001.
- Reset, then RTI -> SDR and shift 32 bits with tdi=0: tdo sequence reads 32'h1234_5001 LSB-first.
- Load IR=4'b1111 via SIR (tdo shows 1,0,0,0 captured), then shift DR: tdo echoes tdi delayed by one tck.
- Load IR=4'b0010 with user_dr_in=8'hA5, capture and shift in 8'h3C: tdo emits A5 LSB-first; at UDR, user_dr_out=8'h3C and user_update is high for one cycle.
- Assert trst mid-SDR under USER: tap_state=TLR immediately, tdo=0, and user_dr_out keeps its old value.
- Build without JTAG_TAP_USER_DR_EN, then IR=4'b0010: behaves as BYPASS and user_update never pulses.
